// File: rtl/base_ram_arbiter_if.sv
// base_ram_arbiter_if: request/ack and SRAM pin bundle shared by the BaseRAM arbiter and its clients
// slave  : arbiter side (takes IF/MEM requests and sram_dq_i, drives acks, rdata, SRAM controls, busy)
// master : client/top-level side (drives requests and sram_dq_i, observes everything else)
interface base_ram_arbiter_if;
  logic        if_req;
  logic [19:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [19:0] sram_addr;
  logic [3:0]  sram_be_n;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [31:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [31:0] sram_dq_i;
  logic        busy;
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata, sram_dq_i,
    output if_ack, if_rdata, mem_ack, mem_rdata, sram_addr, sram_be_n, sram_ce_n,
           sram_oe_n, sram_we_n, sram_dq_o, sram_dq_oe, busy
  );
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata, sram_dq_i,
    input  if_ack, if_rdata, mem_ack, mem_rdata, sram_addr, sram_be_n, sram_ce_n,
           sram_oe_n, sram_we_n, sram_dq_o, sram_dq_oe, busy
  );
endinterface

// File: rtl/base_ram_arbiter.sv
// base_ram_arbiter: fixed-priority (MEM over IF) sequencer for the single BaseRAM SRAM port
// clk, rst : system clock, synchronous active-high reset
// bus      : slave side of base_ram_arbiter_if (IF/MEM req/ack/rdata, SRAM controls and data, busy)
module base_ram_arbiter #(
  parameter int READ_CYCLES = 2,
  parameter int WE_CYCLES   = 1
) (
  input logic               clk,
  input logic               rst,
  base_ram_arbiter_if.slave bus
);
  localparam int MAXC = READ_CYCLES > WE_CYCLES ? READ_CYCLES : WE_CYCLES;
  localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
  typedef enum logic [2:0] {IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, ACK} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_mem_q, sel_mem_d;
  logic [19:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   mem_rdata_q, mem_rdata_d;
  logic          ce_n_q, ce_n_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic [3:0]    be_n_q, be_n_d;
  logic          dq_oe_q, dq_oe_d;
  logic          if_ack_q, if_ack_d;
  logic          mem_ack_q, mem_ack_d;
  logic          wr_d;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_mem_d   = sel_mem_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE:
        if (bus.mem_req) begin
          sel_mem_d = 1'b1;
          addr_d    = bus.mem_addr;
          be_d      = bus.mem_be;
          wdata_d   = bus.mem_wdata;
          cnt_d     = '0;
          state_d   = !bus.mem_we ? READ : (bus.mem_be == 4'h0 ? ACK : WR_SETUP);
        end else if (bus.if_req) begin
          sel_mem_d = 1'b0;
          addr_d    = bus.if_addr;
          cnt_d     = '0;
          state_d   = READ;
        end
      READ:
        if (cnt_q == CW'(READ_CYCLES - 1)) begin
          state_d = ACK;
          if (sel_mem_q) mem_rdata_d = bus.sram_dq_i;
          else if_rdata_d = bus.sram_dq_i;
        end else cnt_d = cnt_q + 1'b1;
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = '0;
      end
      WR_PULSE:
        if (cnt_q == CW'(WE_CYCLES - 1)) state_d = WR_HOLD;
        else cnt_d = cnt_q + 1'b1;
      WR_HOLD: state_d = ACK;
      default: state_d = IDLE;
    endcase
    // SRAM pins are registered, so they are decoded from the state being entered
    wr_d      = state_d inside {WR_SETUP, WR_PULSE, WR_HOLD};
    ce_n_d    = !(wr_d || state_d == READ);
    oe_n_d    = state_d != READ;
    we_n_d    = state_d != WR_PULSE;
    dq_oe_d   = wr_d;
    be_n_d    = state_d == READ ? 4'h0 : (wr_d ? ~be_d : 4'hF);
    if_ack_d  = state_d == ACK && !sel_mem_d;
    mem_ack_d = state_d == ACK && sel_mem_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_mem_q   <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= 4'hF;
      dq_oe_q     <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_mem_q   <= sel_mem_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      be_n_q      <= be_n_d;
      dq_oe_q     <= dq_oe_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
    end
  end
  assign bus.if_ack     = if_ack_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.mem_ack    = mem_ack_q;
  assign bus.mem_rdata  = mem_rdata_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_be_n  = be_n_q;
  assign bus.sram_ce_n  = ce_n_q;
  assign bus.sram_oe_n  = oe_n_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.sram_dq_o  = wdata_q;
  assign bus.sram_dq_oe = dq_oe_q;
  assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_base_ram_arbiter.sv
// tb_base_ram_arbiter: directed table-driven bench for base_ram_arbiter with READ_CYCLES=2, WE_CYCLES=1
module tb_base_ram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  base_ram_arbiter_if b();
  base_ram_arbiter #(.READ_CYCLES(2), .WE_CYCLES(1)) dut (.clk(clk), .rst(rst), .bus(b));
  typedef struct {
    logic        is_mem;
    logic        we;
    logic [3:0]  be;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [31:0] dq;
    int          lat;
    int          ce;
    int          oe;
    int          wel;
    int          dqoe;
    logic [3:0]  be_n;
  } vec_t;
  vec_t tv[7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input vec_t v, input int idx);
    int lat = 0, ce = 0, oe = 0, wel = 0, dqoe = 0, conflict = 0, wrong = 0, bad_dq = 0;
    logic [3:0]  ben = 4'hF;
    logic [19:0] a1 = '0;
    logic        ack, other;
    string       p;
    p = $sformatf("v%0d", idx);
    b.sram_dq_i = v.dq;
    if (v.is_mem) begin
      b.mem_we = v.we; b.mem_be = v.be; b.mem_addr = v.addr; b.mem_wdata = v.wdata; b.mem_req = 1'b1;
    end else begin
      b.if_addr = v.addr; b.if_req = 1'b1;
    end
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      step();
      if (c == 1) a1 = b.sram_addr;
      if (!b.sram_ce_n) begin ce++; ben = b.sram_be_n; end
      if (!b.sram_oe_n) oe++;
      if (!b.sram_we_n) wel++;
      if (b.sram_dq_oe) dqoe++;
      if (!b.sram_oe_n && b.sram_dq_oe) conflict++;
      if (b.sram_dq_oe && b.sram_dq_o !== v.wdata) bad_dq++;
      ack   = v.is_mem ? b.mem_ack : b.if_ack;
      other = v.is_mem ? b.if_ack : b.mem_ack;
      if (other) wrong++;
      if (ack) lat = c;
    end
    b.mem_req = 1'b0;
    b.if_req  = 1'b0;
    chk({p, " ack latency"}, lat, v.lat);
    chk({p, " ce_n low cycles"}, ce, v.ce);
    chk({p, " oe_n low cycles"}, oe, v.oe);
    chk({p, " we_n low cycles"}, wel, v.wel);
    chk({p, " dq_oe cycles"}, dqoe, v.dqoe);
    chk({p, " be_n"}, {28'h0, ben}, {28'h0, v.be_n});
    chk({p, " addr"}, {12'h0, a1}, {12'h0, v.addr});
    chk({p, " oe/dq_oe overlap"}, conflict, 0);
    chk({p, " wrong ack"}, wrong, 0);
    chk({p, " dq_o data"}, bad_dq, 0);
    if (!(v.is_mem && v.we)) chk({p, " rdata"}, v.is_mem ? b.mem_rdata : b.if_rdata, v.dq);
    step();
    chk({p, " busy after ack"}, {31'h0, b.busy}, 0);
  endtask
  initial begin
    int mem_at, if_at, ack0, ack1, n_ack, bad, acks, ce4, ce5;
    logic [19:0] a1, a5;
    logic [31:0] rd1;
    tv[0] = '{1'b0, 1'b0, 4'h0, 20'h00010, 32'h0,        32'h12345678, 3, 2, 2, 0, 0, 4'h0};
    tv[1] = '{1'b1, 1'b1, 4'h3, 20'h00020, 32'hDEADBEEF, 32'h0,        4, 3, 0, 1, 3, 4'hC};
    tv[2] = '{1'b1, 1'b1, 4'h0, 20'h00024, 32'h0BADF00D, 32'h0,        1, 0, 0, 0, 0, 4'hF};
    tv[3] = '{1'b1, 1'b0, 4'h5, 20'h00030, 32'h0,        32'hCAFEF00D, 3, 2, 2, 0, 0, 4'h0};
    tv[4] = '{1'b1, 1'b1, 4'hF, 20'hFFFFF, 32'h00000000, 32'h0,        4, 3, 0, 1, 3, 4'h0};
    tv[5] = '{1'b0, 1'b0, 4'h0, 20'hFFFFF, 32'h0,        32'hFFFFFFFF, 3, 2, 2, 0, 0, 4'h0};
    tv[6] = '{1'b1, 1'b1, 4'h8, 20'h00001, 32'h80000001, 32'h0,        4, 3, 0, 1, 3, 4'h7};
    b.if_req = 0; b.if_addr = 0; b.mem_req = 0; b.mem_we = 0; b.mem_be = 0;
    b.mem_addr = 0; b.mem_wdata = 0; b.sram_dq_i = 0;
    repeat (3) step();
    chk("reset ce/oe/we", {29'h0, b.sram_ce_n, b.sram_oe_n, b.sram_we_n}, 32'h7);
    chk("reset be_n", {28'h0, b.sram_be_n}, 32'hF);
    chk("reset dq_oe/acks/busy", {28'h0, b.sram_dq_oe, b.if_ack, b.mem_ack, b.busy}, 0);
    chk("reset rdata", b.if_rdata | b.mem_rdata, 0);
    chk("reset addr", {12'h0, b.sram_addr}, 0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 7; i++) run(tv[i], i);
    // MEM and IF requests rise together: MEM first, IF granted after the ACK cycle
    b.sram_dq_i = 32'hA5A5A5A5;
    b.mem_we = 0; b.mem_addr = 20'h00040; b.mem_req = 1;
    b.if_addr = 20'h00050; b.if_req = 1;
    mem_at = 0; if_at = 0; a1 = 0;
    for (int c = 1; c <= 20 && if_at == 0; c++) begin
      step();
      if (c == 1) a1 = b.sram_addr;
      if (b.mem_ack && mem_at == 0) begin mem_at = c; b.mem_req = 0; b.sram_dq_i = 32'h5A5A5A5A; end
      if (b.if_ack) begin if_at = c; b.if_req = 0; end
    end
    b.mem_req = 0; b.if_req = 0;
    chk("arb mem_ack cycle", mem_at, 3);
    chk("arb if_ack cycle", if_at, 7);
    chk("arb first addr", {12'h0, a1}, 32'h40);
    chk("arb mem_rdata", b.mem_rdata, 32'hA5A5A5A5);
    chk("arb if_rdata", b.if_rdata, 32'h5A5A5A5A);
    step();
    // reset during WR_PULSE aborts the write with no ack
    b.mem_we = 1; b.mem_be = 4'hF; b.mem_addr = 20'h00077; b.mem_wdata = 32'h13579BDF; b.mem_req = 1;
    step();
    step();
    chk("abort we_n in pulse", {31'h0, b.sram_we_n}, 0);
    rst = 1'b1;
    step();
    chk("abort we_n/ce_n", {30'h0, b.sram_we_n, b.sram_ce_n}, 32'h3);
    chk("abort dq_oe/busy", {30'h0, b.sram_dq_oe, b.busy}, 0);
    rst = 1'b0; b.mem_req = 0;
    acks = 0;
    for (int c = 0; c < 6; c++) begin step(); if (b.mem_ack) acks++; end
    chk("abort no mem_ack", acks, 0);
    run(tv[0], 7);
    // IF req held across ACK: next read granted in the cycle after ACK
    b.sram_dq_i = 32'h11111111; b.if_addr = 20'h00100; b.if_req = 1;
    n_ack = 0; ack0 = 0; ack1 = 0; bad = 0; rd1 = 0; a5 = 0; ce4 = 0; ce5 = 1;
    for (int c = 1; c <= 20 && n_ack < 2; c++) begin
      step();
      if (c == 4) ce4 = int'(b.sram_ce_n);
      if (c == 5) begin ce5 = int'(b.sram_ce_n); a5 = b.sram_addr; end
      if (b.if_ack) begin
        if (!b.sram_ce_n || !b.sram_oe_n) bad++;
        if (n_ack == 0) begin
          ack0 = c; rd1 = b.if_rdata; b.if_addr = 20'h00101; b.sram_dq_i = 32'h22222222;
        end else ack1 = c;
        n_ack++;
      end
    end
    b.if_req = 0;
    chk("b2b first ack", ack0, 3);
    chk("b2b second ack", ack1, 7);
    chk("b2b ce/oe in ACK", bad, 0);
    chk("b2b ce_n idle gap", ce4, 1);
    chk("b2b ce_n regrant", ce5, 0);
    chk("b2b second addr", {12'h0, a5}, 32'h101);
    chk("b2b first rdata", rd1, 32'h11111111);
    chk("b2b second rdata", b.if_rdata, 32'h22222222);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
